// File: rtl/nerv_dbg_trigger_if.sv
// Debug trigger bus between the GDB stub, the NERV core and the trigger unit.
// Groups the stub command channel, the core retire/data-access taps, the
// core stall/halted status and the stop-event channel.
//   slave  : trigger unit side (consumes commands and core taps, emits stall/events)
//   master : stub/core side (issues commands and core taps, consumes stall/events)
interface nerv_dbg_trigger_if #(
    parameter int XLEN = 32,
    parameter int CNTW = 16,
    parameter int IDXW = 4
);
    logic            cmd_vld;
    logic            cmd_rdy;
    logic [2:0]      cmd_op;
    logic [IDXW-1:0] cmd_idx;
    logic [XLEN-1:0] cmd_adr;
    logic [CNTW-1:0] cmd_cnt;

    logic            ret_vld;
    logic [XLEN-1:0] ret_pc;
    logic            mem_vld;
    logic            mem_wen;
    logic [XLEN-1:0] mem_adr;

    logic            cpu_stall;
    logic            halted;

    logic            evt_vld;
    logic            evt_rdy;
    logic [2:0]      evt_cause;
    logic [IDXW-1:0] evt_idx;
    logic [XLEN-1:0] evt_pc;

    modport slave (
        input  cmd_vld, cmd_op, cmd_idx, cmd_adr, cmd_cnt,
        input  ret_vld, ret_pc, mem_vld, mem_wen, mem_adr,
        input  evt_rdy,
        output cmd_rdy, cpu_stall, halted,
        output evt_vld, evt_cause, evt_idx, evt_pc
    );

    modport master (
        output cmd_vld, cmd_op, cmd_idx, cmd_adr, cmd_cnt,
        output ret_vld, ret_pc, mem_vld, mem_wen, mem_adr,
        output evt_rdy,
        input  cmd_rdy, cpu_stall, halted,
        input  evt_vld, evt_cause, evt_idx, evt_pc
    );
endinterface

// File: rtl/nerv_dbg_trigger.sv
// Hardware debug trigger and run-control unit for the NERV core.
// Holds BNUM PC breakpoints and WNUM store watchpoints, implements halt,
// resume and N-instruction single-step by stalling the core, and reports
// every stop to the stub as an event (cause, comparator index, last PC).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : nerv_dbg_trigger_if.slave (command, core taps, stall, event)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_RUN    | core free-running, triggers armed
// S_STEP   | core running for a bounded number of retirements
// S_REPORT | core stalled, stop event presented to the stub
// S_HALT   | core stalled, waiting for RESUME/STEP
module nerv_dbg_trigger #(
    parameter int XLEN = 32,
    parameter int BNUM = 4,
    parameter int WNUM = 2,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    nerv_dbg_trigger_if.slave   bus
);
    localparam int IDXW = 4;

    localparam logic [2:0] OP_HALT    = 3'd1;
    localparam logic [2:0] OP_RESUME  = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BRK = 3'd4;
    localparam logic [2:0] OP_CLR_BRK = 3'd5;
    localparam logic [2:0] OP_SET_WTC = 3'd6;
    localparam logic [2:0] OP_CLR_WTC = 3'd7;

    localparam logic [2:0] CAUSE_HALT = 3'd1;
    localparam logic [2:0] CAUSE_STEP = 3'd2;
    localparam logic [2:0] CAUSE_BRK  = 3'd3;
    localparam logic [2:0] CAUSE_WTC  = 3'd4;

    typedef enum logic [1:0] {S_RUN, S_STEP, S_REPORT, S_HALT} state_t;

    state_t             state_q;
    logic               cpu_stall_q;
    logic               halted_q;
    logic               cmd_rdy_q;
    logic               evt_vld_q;
    logic [2:0]         evt_cause_q;
    logic [IDXW-1:0]    evt_idx_q;
    logic [XLEN-1:0]    evt_pc_q;
    logic [XLEN-1:0]    last_pc_q, last_pc_d;
    logic [CNTW-1:0]    cnt_q;
    logic               skip_q;

    logic [XLEN-1:0]    brk_adr_q [BNUM];
    logic [BNUM-1:0]    brk_en_q;
    logic [XLEN-1:0]    wtc_adr_q [WNUM];
    logic [WNUM-1:0]    wtc_en_q;

    logic               active;
    logic               cmd_fire;
    logic               brk_hit, wtc_hit, step_hit, halt_req, trig;
    logic [IDXW-1:0]    brk_idx, wtc_idx;
    logic [2:0]         cause_d;
    logic [IDXW-1:0]    idx_d;

    assign active    = (state_q == S_RUN) || (state_q == S_STEP);
    assign cmd_fire  = bus.cmd_vld && cmd_rdy_q;
    assign last_pc_d = bus.ret_vld ? bus.ret_pc : last_pc_q;

    // Descending scan so the lowest matching comparator is the one reported.
    always_comb begin
        brk_hit = 1'b0;
        brk_idx = '0;
        for (int i = BNUM - 1; i >= 0; i--) begin
            if (active && bus.ret_vld && !skip_q && brk_en_q[i] &&
                (bus.ret_pc == brk_adr_q[i])) begin
                brk_hit = 1'b1;
                brk_idx = IDXW'(i);
            end
        end
    end

    // Word-granular watch: the two byte-offset bits are masked out.
    always_comb begin
        wtc_hit = 1'b0;
        wtc_idx = '0;
        for (int j = WNUM - 1; j >= 0; j--) begin
            if (active && bus.mem_vld && bus.mem_wen && wtc_en_q[j] &&
                (((bus.mem_adr ^ wtc_adr_q[j]) & ~XLEN'(3)) == '0)) begin
                wtc_hit = 1'b1;
                wtc_idx = IDXW'(j);
            end
        end
    end

    assign step_hit = (state_q == S_STEP) && bus.ret_vld && (cnt_q == CNTW'(1));
    assign halt_req = active && cmd_fire && (bus.cmd_op == OP_HALT);
    assign trig     = brk_hit || wtc_hit || step_hit || halt_req;

    always_comb begin
        cause_d = CAUSE_HALT;
        idx_d   = '0;
        if (brk_hit) begin
            cause_d = CAUSE_BRK;
            idx_d   = brk_idx;
        end else if (wtc_hit) begin
            cause_d = CAUSE_WTC;
            idx_d   = wtc_idx;
        end else if (step_hit) begin
            cause_d = CAUSE_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HALT;
            cpu_stall_q <= 1'b1;
            halted_q    <= 1'b1;
            cmd_rdy_q   <= 1'b1;
            evt_vld_q   <= 1'b0;
            evt_cause_q <= '0;
            evt_idx_q   <= '0;
            evt_pc_q    <= '0;
            last_pc_q   <= '0;
            cnt_q       <= '0;
            skip_q      <= 1'b0;
            brk_en_q    <= '0;
            wtc_en_q    <= '0;
            for (int i = 0; i < BNUM; i++) brk_adr_q[i] <= '0;
            for (int j = 0; j < WNUM; j++) wtc_adr_q[j] <= '0;
        end else begin
            last_pc_q <= last_pc_d;

            // Comparator configuration; out-of-range indices match no slot.
            if (cmd_fire) begin
                for (int i = 0; i < BNUM; i++) begin
                    if (bus.cmd_idx == IDXW'(i)) begin
                        if (bus.cmd_op == OP_SET_BRK) begin
                            brk_en_q[i]  <= 1'b1;
                            brk_adr_q[i] <= bus.cmd_adr;
                        end else if (bus.cmd_op == OP_CLR_BRK) begin
                            brk_en_q[i]  <= 1'b0;
                        end
                    end
                end
                for (int j = 0; j < WNUM; j++) begin
                    if (bus.cmd_idx == IDXW'(j)) begin
                        if (bus.cmd_op == OP_SET_WTC) begin
                            wtc_en_q[j]  <= 1'b1;
                            wtc_adr_q[j] <= bus.cmd_adr;
                        end else if (bus.cmd_op == OP_CLR_WTC) begin
                            wtc_en_q[j]  <= 1'b0;
                        end
                    end
                end
            end

            // Breakpoint suppression lasts only until the first retirement.
            if (active && bus.ret_vld) skip_q <= 1'b0;
            if ((state_q == S_STEP) && bus.ret_vld) cnt_q <= cnt_q - CNTW'(1);

            case (state_q)
                S_RUN, S_STEP: begin
                    if (trig) begin
                        state_q     <= S_REPORT;
                        cpu_stall_q <= 1'b1;
                        cmd_rdy_q   <= 1'b0;
                        evt_vld_q   <= 1'b1;
                        evt_cause_q <= cause_d;
                        evt_idx_q   <= idx_d;
                        evt_pc_q    <= last_pc_d;
                    end
                end
                S_REPORT: begin
                    if (bus.evt_rdy) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        cmd_rdy_q <= 1'b1;
                        evt_vld_q <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (cmd_fire && (bus.cmd_op == OP_RESUME)) begin
                        state_q     <= S_RUN;
                        cpu_stall_q <= 1'b0;
                        halted_q    <= 1'b0;
                        skip_q      <= 1'b1;
                    end else if (cmd_fire && (bus.cmd_op == OP_STEP)) begin
                        state_q     <= S_STEP;
                        cpu_stall_q <= 1'b0;
                        halted_q    <= 1'b0;
                        skip_q      <= 1'b1;
                        cnt_q       <= (bus.cmd_cnt == '0) ? CNTW'(1) : bus.cmd_cnt;
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign bus.cpu_stall = cpu_stall_q;
    assign bus.halted    = halted_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.evt_vld   = evt_vld_q;
    assign bus.evt_cause = evt_cause_q;
    assign bus.evt_idx   = evt_idx_q;
    assign bus.evt_pc    = evt_pc_q;
endmodule

// File: tb/tb_nerv_dbg_trigger.sv
module tb_nerv_dbg_trigger;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nerv_dbg_trigger_if #(.XLEN(32), .CNTW(16), .IDXW(4)) bus ();

    nerv_dbg_trigger #(.XLEN(32), .BNUM(4), .WNUM(2), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  cause;
        logic [3:0]  idx;
        logic [31:0] pc;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] HALT = 3'd1, RESUME = 3'd2, STEP = 3'd3,
                           SET_BRK = 3'd4, CLR_BRK = 3'd5, SET_WTC = 3'd6, CLR_WTC = 3'd7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void expect_evt(input logic [2:0] c, input logic [3:0] i, input logic [31:0] p);
        evt_t e;
        e.cause = c;
        e.idx   = i;
        e.pc    = p;
        exp_q.push_back(e);
    endfunction

    // Scoreboard monitor: compares each accepted event with the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.evt_vld && bus.evt_rdy) begin : mon
                evt_t e;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cause=%0d pc=%0h required none",
                             bus.evt_cause, bus.evt_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_cause", 32'(bus.evt_cause), 32'(e.cause));
                    chk("evt_idx",   32'(bus.evt_idx),   32'(e.idx));
                    chk("evt_pc",    bus.evt_pc,         e.pc);
                end
            end
        end
    end

    task automatic cmd(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] adr,
                       input logic [15:0] cnt);
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = op;
        bus.cmd_idx = idx;
        bus.cmd_adr = adr;
        bus.cmd_cnt = cnt;
        @(posedge clk); #1;
        bus.cmd_vld = 1'b0;
        bus.cmd_op  = 3'd0;
    endtask

    task automatic retire(input logic [31:0] pc);
        bus.ret_vld = 1'b1;
        bus.ret_pc  = pc;
        @(posedge clk); #1;
        bus.ret_vld = 1'b0;
    endtask

    task automatic access(input logic [31:0] adr, input logic wen);
        bus.mem_vld = 1'b1;
        bus.mem_wen = wen;
        bus.mem_adr = adr;
        @(posedge clk); #1;
        bus.mem_vld = 1'b0;
        bus.mem_wen = 1'b0;
    endtask

    task automatic ack();
        int n = 0;
        while (!bus.evt_vld && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.evt_vld) begin
            checks++;
            errors++;
            $display("FAIL evt_timeout evt_vld=0 required 1 within 20 cycles");
        end else begin
            bus.evt_rdy = 1'b1;
            @(posedge clk); #1;
            bus.evt_rdy = 1'b0;
            chk("halted_after_ack", 32'(bus.halted), 32'd1);
            chk("evt_vld_after_ack", 32'(bus.evt_vld), 32'd0);
        end
    endtask

    initial begin
        bus.cmd_vld = 1'b0; bus.cmd_op = '0; bus.cmd_idx = '0; bus.cmd_adr = '0; bus.cmd_cnt = '0;
        bus.ret_vld = 1'b0; bus.ret_pc = '0;
        bus.mem_vld = 1'b0; bus.mem_wen = 1'b0; bus.mem_adr = '0;
        bus.evt_rdy = 1'b0;

        #1 rst = 1'b1;
        #2;
        chk("rst_halted",    32'(bus.halted),    32'd1);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd1);
        chk("rst_evt_vld",   32'(bus.evt_vld),   32'd0);
        chk("rst_cmd_rdy",   32'(bus.cmd_rdy),   32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1: three-instruction step
        expect_evt(3'd2, 4'd0, 32'h8);
        cmd(STEP, 4'd0, 32'h0, 16'd3);
        chk("step_stall_low", 32'(bus.cpu_stall), 32'd0);
        retire(32'h0);
        retire(32'h4);
        chk("step_still_running", 32'(bus.cpu_stall), 32'd0);
        retire(32'h8);
        chk("step_stall_after_3rd", 32'(bus.cpu_stall), 32'd1);
        chk("step_evt_vld", 32'(bus.evt_vld), 32'd1);
        chk("step_not_halted_in_report", 32'(bus.halted), 32'd0);
        ack();

        // 2: breakpoint and skip-first
        cmd(SET_BRK, 4'd1, 32'h40, 16'd0);
        expect_evt(3'd3, 4'd1, 32'h40);
        cmd(RESUME, 4'd0, 32'h0, 16'd0);
        retire(32'h3C);
        retire(32'h40);
        ack();
        cmd(RESUME, 4'd0, 32'h0, 16'd0);
        retire(32'h40);
        chk("skip_first_no_trap", 32'(bus.cpu_stall), 32'd0);
        expect_evt(3'd3, 4'd1, 32'h40);
        retire(32'h40);
        ack();
        cmd(CLR_BRK, 4'd1, 32'h0, 16'd0);

        // 3: store watchpoint, word granular; loads ignored
        cmd(SET_WTC, 4'd0, 32'h1002, 16'd0);
        cmd(RESUME, 4'd0, 32'h0, 16'd0);
        access(32'h1000, 1'b0);
        chk("load_no_trigger", 32'(bus.cpu_stall), 32'd0);
        expect_evt(3'd4, 4'd0, 32'h40);
        access(32'h1000, 1'b1);
        ack();
        cmd(CLR_WTC, 4'd0, 32'h0, 16'd0);

        // 4: BRK beats STEP, lowest index wins; STEP cnt=0 acts as 1
        cmd(SET_BRK, 4'd3, 32'h20, 16'd0);
        cmd(SET_BRK, 4'd2, 32'h20, 16'd0);
        cmd(STEP, 4'd0, 32'h0, 16'd2);
        retire(32'h1C);
        chk("step2_running", 32'(bus.cpu_stall), 32'd0);
        expect_evt(3'd3, 4'd2, 32'h20);
        retire(32'h20);
        ack();
        cmd(CLR_BRK, 4'd2, 32'h0, 16'd0);
        cmd(CLR_BRK, 4'd3, 32'h0, 16'd0);
        expect_evt(3'd2, 4'd0, 32'h24);
        cmd(STEP, 4'd0, 32'h0, 16'd0);
        retire(32'h24);
        chk("step0_stops_after_one", 32'(bus.cpu_stall), 32'd1);
        ack();

        // out-of-range index is ignored
        cmd(SET_BRK, 4'd5, 32'h50, 16'd0);
        cmd(RESUME, 4'd0, 32'h0, 16'd0);
        retire(32'h4C);
        retire(32'h50);
        chk("oor_idx_ignored", 32'(bus.cpu_stall), 32'd0);

        // 5: HALT with same-cycle retire, stalled event channel
        expect_evt(3'd1, 4'd0, 32'h10);
        bus.ret_vld = 1'b1;
        bus.ret_pc  = 32'h10;
        cmd(HALT, 4'd0, 32'h0, 16'd0);
        bus.ret_vld = 1'b0;
        chk("halt_stall", 32'(bus.cpu_stall), 32'd1);
        chk("report_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_evt_vld",   32'(bus.evt_vld),   32'd1);
            chk("hold_evt_cause", 32'(bus.evt_cause), 32'd1);
            chk("hold_evt_pc",    bus.evt_pc,         32'h10);
            chk("hold_cmd_rdy",   32'(bus.cmd_rdy),   32'd0);
        end
        ack();

        // HALT while halted is ignored
        cmd(HALT, 4'd0, 32'h0, 16'd0);
        @(posedge clk); #1;
        chk("halt_in_halt_no_evt", 32'(bus.evt_vld), 32'd0);
        chk("halt_in_halt_halted", 32'(bus.halted),  32'd1);

        // 6: async reset during a pending step
        cmd(SET_BRK, 4'd0, 32'h80, 16'd0);
        cmd(STEP, 4'd0, 32'h0, 16'd5);
        retire(32'h0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_halted",  32'(bus.halted),    32'd1);
        chk("mid_rst_stall",   32'(bus.cpu_stall), 32'd1);
        chk("mid_rst_evt_vld", 32'(bus.evt_vld),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_evt", 32'(bus.evt_vld), 32'd0);
        cmd(RESUME, 4'd0, 32'h0, 16'd0);
        retire(32'h80);
        retire(32'h80);
        retire(32'h80);
        chk("post_rst_brk_cleared", 32'(bus.cpu_stall), 32'd0);
        expect_evt(3'd1, 4'd0, 32'h80);
        cmd(HALT, 4'd0, 32'h0, 16'd0);
        ack();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
